game_flow_ctrl: RTL

Top-level sequencer for the player ship datapath and level flow. It owns lives and level bookkeeping, gates the playfield with run_o, and times the hit-flash pause and level-complete banner from the frame tick. It also decides the game-over and game-won conditions. It sits between the button/frame-tick logic and the player, enemy and bullet datapaths. Those datapaths advance only while run_o=1 and reload on level_load_o.

---
 rtl/game_flow_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: lives/level sequencer gating the playfield, hit-flash pause and level banner
module game_flow_ctrl #(
  parameter int lives_init_p    = 3,
  parameter int lives_max_p     = 3,
  parameter int levels_p        = 8,
  parameter int flash_frames_p  = 60,
  parameter int flash_period_p  = 8,
  parameter int banner_frames_p = 90
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_tick_i,
  input  logic       button_i,
  input  logic       hit_i,
  input  logic       level_clear_i,
  output logic       run_o,
  output logic       player_visible_o,
  output logic       level_load_o,
  output logic       level_beat_o,
  output logic       banner_o,
  output logic       game_over_o,
  output logic       game_won_o,
  output logic [1:0] lives_o,
  output logic [3:0] level_o,
  output logic [6:0] state_o
);
  localparam int tmax_lp = flash_frames_p > banner_frames_p ? flash_frames_p : banner_frames_p;
  localparam int tw_lp   = $clog2(tmax_lp);
  typedef enum logic [6:0] {
    IDLE       = 7'b0000001,
    PLAY       = 7'b0000010,
    HIT_FLASH  = 7'b0000100,
    HIT_WAIT   = 7'b0001000,
    LEVEL_DONE = 7'b0010000,
    GAME_OVER  = 7'b0100000,
    GAME_WON   = 7'b1000000
  } state_e;
  state_e           state_q, state_d;
  logic [tw_lp-1:0] timer_q, timer_d;
  logic [1:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic [31:0]      phase;
  logic             button_q, btn_rise, load_d, beat_d, vis_d;
  logic             run_q, vis_q, load_q, beat_q, banner_q, over_q, won_q;
  assign btn_rise = button_i & ~button_q;
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    load_d  = 1'b0;
    beat_d  = 1'b0;
    case (state_q)
      IDLE: if (btn_rise) begin
        state_d = PLAY;
        load_d  = 1'b1;
      end
      PLAY: if (hit_i) begin
        state_d = lives_q > 2'd1 ? HIT_FLASH : GAME_OVER;
        lives_d = lives_q > 2'd1 ? lives_q - 2'd1 : 2'd0;
      end else if (level_clear_i) begin
        beat_d  = 1'b1;
        state_d = level_q == 4'(levels_p) ? GAME_WON : LEVEL_DONE;
        if (level_q != 4'(levels_p) && !level_q[0] && lives_q < 2'(lives_max_p))
          lives_d = lives_q + 2'd1;
      end
      HIT_FLASH: if (frame_tick_i && timer_q == tw_lp'(flash_frames_p - 1)) state_d = HIT_WAIT;
      HIT_WAIT: if (btn_rise) state_d = PLAY;
      LEVEL_DONE: if (frame_tick_i && timer_q == tw_lp'(banner_frames_p - 1)) begin
        state_d = PLAY;
        level_d = level_q + 4'd1;
        load_d  = 1'b1;
      end
      GAME_OVER: if (btn_rise) begin
        state_d = PLAY;
        lives_d = 2'(lives_init_p);
        level_d = 4'd1;
        load_d  = 1'b1;
      end
      GAME_WON: state_d = GAME_WON;
      default: state_d = IDLE;
    endcase
    // timers restart on every state entry so each pause is measured from its own start
    timer_d = state_d != state_q ? '0
            : timer_q + tw_lp'(frame_tick_i && (state_q == HIT_FLASH || state_q == LEVEL_DONE));
    phase   = 32'(timer_d) / flash_period_p;
    vis_d   = state_d == HIT_FLASH ? phase[0]
            : state_d inside {PLAY, HIT_WAIT, LEVEL_DONE, GAME_WON};
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      lives_q  <= 2'(lives_init_p);
      level_q  <= 4'd1;
      button_q <= 1'b1;
      run_q    <= 1'b0;
      vis_q    <= 1'b0;
      load_q   <= 1'b0;
      beat_q   <= 1'b0;
      banner_q <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      button_q <= button_i;
      run_q    <= state_d == PLAY;
      vis_q    <= vis_d;
      load_q   <= load_d;
      beat_q   <= beat_d;
      banner_q <= state_d == LEVEL_DONE;
      over_q   <= state_d == GAME_OVER;
      won_q    <= state_d == GAME_WON;
    end
  end
  assign {run_o, player_visible_o, level_load_o, level_beat_o} = {run_q, vis_q, load_q, beat_q};
  assign {banner_o, game_over_o, game_won_o} = {banner_q, over_q, won_q};
  assign lives_o = lives_q;
  assign level_o = level_q;
  assign state_o = state_q;
endmodule
